t_skew_stats: RTL and testbench

- Windowed statistics engine directly downstream of the skew thermometer-to-binary sampler.
- Consumes the per-cycle skew code and accumulates a power-of-two window of samples.
- Reports min, max, truncated mean, span (max-min) and a saturation count through a valid/ack result handshake.
- Runs in the sampling clock domain, so the skew code is used without synchronisation.

---
 rtl/t_skew_pkg.sv | 11 +
 rtl/t_skew_stats_if.sv | 31 +++
 rtl/t_skew_minmax.sv | 36 +++
 rtl/t_skew_stats.sv | 126 ++++++++++++
 tb/tb_t_skew_stats.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/t_skew_pkg.sv
// rtl/t_skew_pkg.sv - shared types and helpers for the skew statistics engine
package t_skew_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} t_skew_stats_state_e;

  // Shared with the upstream sampler so both ends agree on the code width.
  function automatic int skew_code_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/t_skew_stats_if.sv
// rtl/t_skew_stats_if.sv - skew sample input, start/busy and result handshake bundle
interface t_skew_stats_if #(
  parameter int STAGES   = 64,
  parameter int LOG2_WIN = 8
);
  import t_skew_pkg::*;

  localparam int CODE_W = skew_code_width(STAGES);

  logic [CODE_W-1:0] skew_code;
  logic              start;
  logic              busy;
  logic              res_valid;
  logic              res_ack;
  logic [CODE_W-1:0] min_code;
  logic [CODE_W-1:0] max_code;
  logic [CODE_W-1:0] mean_code;
  logic [CODE_W-1:0] span_code;
  logic [LOG2_WIN:0] sat_count;

  modport master (
    output skew_code, start, res_ack,
    input  busy, res_valid, min_code, max_code, mean_code, span_code, sat_count
  );

  modport slave (
    input  skew_code, start, res_ack,
    output busy, res_valid, min_code, max_code, mean_code, span_code, sat_count
  );

endinterface

// File: rtl/t_skew_minmax.sv
// rtl/t_skew_minmax.sv - running min/max tracker with clear and update strobes
module t_skew_minmax #(
  parameter int W        = 7,
  parameter int MIN_INIT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         upd,
  input  logic [W-1:0] sample,
  output logic [W-1:0] min_q,
  output logic [W-1:0] max_q,
  output logic [W-1:0] min_nxt,
  output logic [W-1:0] max_nxt
);

  // Look-ahead values let the owner capture a result that includes this sample.
  always_comb begin
    min_nxt = (sample < min_q) ? sample : min_q;
    max_nxt = (sample > max_q) ? sample : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clr) begin
      min_q <= W'(MIN_INIT);
      max_q <= '0;
    end else if (upd) begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

endmodule

// File: rtl/t_skew_stats.sv
// rtl/t_skew_stats.sv - windowed min/max/mean/span/saturation statistics on the skew code
module t_skew_stats #(
  parameter int STAGES   = 64,
  parameter int LOG2_WIN = 8,
  parameter int SETTLE   = 2
) (
  input  logic          clk,
  input  logic          rst,
  t_skew_stats_if.slave bus
);
  import t_skew_pkg::*;

  localparam int CODE_W = skew_code_width(STAGES);
  localparam int SUM_W  = CODE_W + LOG2_WIN;
  localparam int CNT_W  = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0]  WIN      = CNT_W'(2 ** LOG2_WIN);
  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(STAGES);

  t_skew_stats_state_e state_q, state_d;
  logic [3:0]        settle_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  sum_q, sum_nxt;
  logic [CNT_W-1:0]  sat_q, sat_nxt;
  logic [CODE_W-1:0] sample_q;
  logic [CODE_W-1:0] min_q, max_q, min_nxt, max_nxt;
  logic              clr, upd, load;
  logic              busy_q, valid_q;
  logic [CODE_W-1:0] min_r, max_r, mean_r, span_r;
  logic [CNT_W-1:0]  sat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:               if (bus.start) state_d = (SETTLE == 0) ? ACCUM : t_skew_pkg::SETTLE;
      t_skew_pkg::SETTLE: if (settle_q == 4'd1) state_d = ACCUM;
      ACCUM:              if (cnt_q == WIN) state_d = DONE;
      DONE:               if (bus.res_ack) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // First ACCUM cycle only primes sample_q; the next WIN cycles accumulate it.
  always_comb begin
    clr  = (state_q == IDLE) && bus.start;
    upd  = (state_q == ACCUM) && (cnt_q != '0);
    load = (state_q == ACCUM) && (cnt_q == WIN);
  end

  assign sum_nxt = sum_q + SUM_W'(sample_q);
  assign sat_nxt = sat_q + CNT_W'(sample_q == CODE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      sat_q    <= '0;
    end else begin
      sample_q <= bus.skew_code;
      if (clr) begin
        settle_q <= 4'(SETTLE);
        cnt_q    <= '0;
        sum_q    <= '0;
        sat_q    <= '0;
      end else begin
        if (state_q == t_skew_pkg::SETTLE) settle_q <= settle_q - 4'd1;
        if (state_q == ACCUM) cnt_q <= cnt_q + CNT_W'(1);
        if (upd) begin
          sum_q <= sum_nxt;
          sat_q <= sat_nxt;
        end
      end
    end
  end

  t_skew_minmax #(.W(CODE_W), .MIN_INIT(STAGES)) u_minmax (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .upd     (upd),
    .sample  (sample_q),
    .min_q   (min_q),
    .max_q   (max_q),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_r   <= '0;
      max_r   <= '0;
      mean_r  <= '0;
      span_r  <= '0;
      sat_r   <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (load) begin
        valid_q <= 1'b1;
        min_r   <= min_nxt;
        max_r   <= max_nxt;
        mean_r  <= sum_nxt[SUM_W-1:LOG2_WIN];
        span_r  <= max_nxt - min_nxt;
        sat_r   <= sat_nxt;
      end else if ((state_q == DONE) && bus.res_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.min_code  = min_r;
  assign bus.max_code  = max_r;
  assign bus.mean_code = mean_r;
  assign bus.span_code = span_r;
  assign bus.sat_count = sat_r;

endmodule

// File: tb/tb_t_skew_stats.sv
// tb/tb_t_skew_stats.sv - randomized self-checking bench for t_skew_stats
module tb_t_skew_stats;
  localparam int STAGES   = 64;
  localparam int LOG2_WIN = 2;
  localparam int SETTLE   = 2;
  localparam int WIN      = 4;
  localparam int CODE_W   = 7;
  localparam int SEQ_N    = SETTLE + WIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;

  t_skew_stats_if #(.STAGES(STAGES), .LOG2_WIN(LOG2_WIN)) bus ();

  t_skew_stats #(.STAGES(STAGES), .LOG2_WIN(LOG2_WIN), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference statistics over the window part of a sequence (first SETTLE entries discarded).
  function automatic logic [30:0] model(input int seq[SEQ_N]);
    int mn = STAGES, mx = 0, sum = 0, sat = 0;
    for (int i = SETTLE; i < SEQ_N; i++) begin
      if (seq[i] < mn) mn = seq[i];
      if (seq[i] > mx) mx = seq[i];
      sum += seq[i];
      if (seq[i] == STAGES) sat++;
    end
    return {CODE_W'(mn), CODE_W'(mx), CODE_W'(sum / WIN), CODE_W'(mx - mn), 3'(sat)};
  endfunction

  function automatic logic [30:0] observed();
    return {bus.min_code, bus.max_code, bus.mean_code, bus.span_code, bus.sat_count};
  endfunction

  task automatic drive_window(input int seq[SEQ_N], output int lat, output bit busy_drop);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.skew_code = CODE_W'(seq[0]);
    lat = -1;
    busy_drop = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      bus.skew_code = (e < SEQ_N) ? CODE_W'(seq[e]) : CODE_W'($urandom_range(0, STAGES));
      @(negedge clk);
      if (!bus.busy) busy_drop = 1'b1;
      if (bus.res_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic ack_result();
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    ncmp++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      nfail++; $display("FAIL reset_flags: got %b want 00", {bus.busy, bus.res_valid});
    end
    ncmp++;
    if (observed() !== 31'h0) begin
      nfail++; $display("FAIL reset_results: got %h want 0", observed());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_window(input string name, input int seq[SEQ_N]);
    int lat; bit bd;
    logic [30:0] exp;
    exp = model(seq);
    drive_window(seq, lat, bd);
    ncmp++;
    if (lat !== 7) begin
      nfail++; $display("FAIL %s_latency: got %0d want 7", name, lat);
    end
    ncmp++;
    if (bd !== 1'b0) begin
      nfail++; $display("FAIL %s_busy: busy dropped during window, want held high", name);
    end
    ncmp++;
    if (observed() !== exp) begin
      nfail++; $display("FAIL %s_results: got %h want %h", name, observed(), exp);
    end
    ack_result();
    @(negedge clk);
    ncmp++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      nfail++; $display("FAIL %s_ack: valid/busy got %b want 00", name, {bus.res_valid, bus.busy});
    end
  endtask

  task automatic test_hold_and_ack();
    int seq[SEQ_N] = '{63, 63, 1, 2, 2, 2};
    int lat; bit bd; bit bad_hold = 1'b0; bit busy_seen = 1'b0;
    logic [30:0] exp;
    exp = model(seq);
    drive_window(seq, lat, bd);
    ncmp++;
    if (bus.mean_code !== 7'd1) begin
      nfail++; $display("FAIL trunc_mean: got %0d want 1", bus.mean_code);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.start = 1'($urandom_range(0, 1));
      bus.skew_code = CODE_W'($urandom_range(0, STAGES));
      @(negedge clk);
      if ({bus.res_valid, bus.busy, observed()} !== {2'b11, exp}) bad_hold = 1'b1;
    end
    ncmp++;
    if (bad_hold !== 1'b0) begin
      nfail++; $display("FAIL hold: outputs changed while waiting for ack, last got %h want %h", observed(), exp);
    end
    bus.start = 1'b1;
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.res_ack = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.res_valid !== 1'b0) begin
      nfail++; $display("FAIL ack_start_valid: got %b want 0", bus.res_valid);
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.res_valid) busy_seen = 1'b1;
    end
    ncmp++;
    if (busy_seen !== 1'b0) begin
      nfail++; $display("FAIL ack_start_idle: busy/valid seen %b want 0", busy_seen);
    end
    ncmp++;
    if (observed() !== exp) begin
      nfail++; $display("FAIL keep_after_ack: got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_random();
    int seq[SEQ_N];
    for (int n = 0; n < 6; n++) begin
      foreach (seq[i]) seq[i] = ($urandom_range(0, 3) == 0) ? STAGES : int'($urandom_range(0, STAGES));
      test_window("random", seq);
    end
  endtask

  task automatic test_reset_mid_accum();
    int seq[SEQ_N] = '{5, 5, 5, 5, 5, 5};
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.skew_code = 7'd30;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    ncmp++;
    if (bus.busy !== 1'b1) begin
      nfail++; $display("FAIL abort_busy_before: got %b want 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    ncmp++;
    if ({bus.busy, bus.res_valid, observed()} !== 33'h0) begin
      nfail++; $display("FAIL async_reset: got %h want 0", {bus.busy, bus.res_valid, observed()});
    end
    @(negedge clk);
    rst = 1'b0;
    test_window("after_abort", seq);
  endtask

  initial begin
    bus.skew_code = '0;
    bus.start = 1'b0;
    bus.res_ack = 1'b0;
    test_reset();
    test_window("constant", '{10, 10, 10, 10, 10, 10});
    test_window("settle_discard", '{63, 63, 3, 9, 5, 7});
    test_window("saturation", '{0, 12, 64, 64, 0, 1});
    test_hold_and_ack();
    test_random();
    test_reset_mid_accum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
